// File: rtl/display7seg_pkg.sv
// display7seg_pkg: active-low 7-segment codes and the shared code-to-pattern decoder.
package display7seg_pkg;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Returns {g,f,e,d,c,b,a}; codes 10-15 are blank unless hex_mode is set.
  function automatic logic [6:0] seg_decode(input logic [3:0] code, input logic hex_mode);
    case (code)
      4'h0: seg_decode = SEG_0[6:0];
      4'h1: seg_decode = SEG_1[6:0];
      4'h2: seg_decode = SEG_2[6:0];
      4'h3: seg_decode = SEG_3[6:0];
      4'h4: seg_decode = SEG_4[6:0];
      4'h5: seg_decode = SEG_5[6:0];
      4'h6: seg_decode = SEG_6[6:0];
      4'h7: seg_decode = SEG_7[6:0];
      4'h8: seg_decode = SEG_8[6:0];
      4'h9: seg_decode = SEG_9[6:0];
      4'hA: seg_decode = hex_mode ? SEG_A[6:0] : SEG_BLANK[6:0];
      4'hB: seg_decode = hex_mode ? SEG_B[6:0] : SEG_BLANK[6:0];
      4'hC: seg_decode = hex_mode ? SEG_C[6:0] : SEG_BLANK[6:0];
      4'hD: seg_decode = hex_mode ? SEG_D[6:0] : SEG_BLANK[6:0];
      4'hE: seg_decode = hex_mode ? SEG_E[6:0] : SEG_BLANK[6:0];
      default: seg_decode = hex_mode ? SEG_F[6:0] : SEG_BLANK[6:0];
    endcase
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 4-bit code to active-low 7-segment pattern.
module seg7_decode
  import display7seg_pkg::*;
#(
  parameter int HEX_MODE = 0
) (
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);
  assign o_seg = seg_decode(i_code, HEX_MODE != 0);
endmodule

// File: rtl/display7seg_mux.sv
// display7seg_mux: double-buffered, frame-synchronous multiplexed 7-segment driver.
// Define LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module display7seg_mux
  import display7seg_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int DIV      = 50000,
  parameter int HEX_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  input  logic              load_i,
  input  logic [4*NDIG-1:0] digits_i,
  input  logic [NDIG-1:0]   dp_i,
  output logic [7:0]        seg_o,
  output logic [NDIG-1:0]   an_o,
  output logic              frame_done_o,
  output logic              pending_o
);
  localparam int PW = $clog2(DIV);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;

  logic [PW-1:0]     r_presc;
  logic [IW-1:0]     r_idx;
  logic [4*NDIG-1:0] r_shadow, r_active;
  logic [NDIG-1:0]   r_sh_dp, r_act_dp;
  logic [7:0]        r_seg;
  logic [NDIG-1:0]   r_an;
  logic              r_frame_done, r_pending;
  logic              w_tick, w_wrap, w_dark, w_blank, w_dp;
  logic [3:0]        w_code;
  logic [6:0]        w_seg7;

  assign w_tick = enable_i && (r_presc == PW'(DIV - 1));
  assign w_wrap = w_tick && (r_idx == IW'(NDIG - 1));
  assign w_dark = !enable_i || w_tick;
  assign w_code = r_active[r_idx*4 +: 4];
  assign w_dp   = r_act_dp[r_idx];

  seg7_decode #(.HEX_MODE(HEX_MODE)) u_dec (.i_code(w_code), .o_seg(w_seg7));

`ifdef LEAD_ZERO_BLANK_EN
  logic [NDIG-1:0] w_lz;
  logic            w_z;
  // A digit is a leading zero when it and every digit to its left is a plain 0.
  always_comb begin
    w_lz = '0;
    w_z  = 1'b1;
    for (int k = NDIG - 1; k > 0; k--) begin
      w_z     = w_z && (r_active[4*k +: 4] == 4'd0) && !r_act_dp[k];
      w_lz[k] = w_z;
    end
  end
  assign w_blank = w_lz[r_idx];
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_sh_dp      <= '0;
      r_active     <= '0;
      r_act_dp     <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_seg        <= SEG_BLANK;
      r_an         <= '1;
    end else begin
      r_presc      <= (!enable_i || w_tick) ? '0 : r_presc + 1'b1;
      r_idx        <= !enable_i ? '0 : !w_tick ? r_idx : (r_idx == IW'(NDIG - 1)) ? '0 : r_idx + 1'b1;
      r_frame_done <= w_wrap;
      r_an         <= w_dark ? '1 : ~(NDIG'(1) << r_idx);
      r_seg        <= (w_dark || w_blank) ? SEG_BLANK : {~w_dp, w_seg7};
      // Commit takes the old shadow even if a load lands on the same edge.
      if (w_wrap && r_pending) begin
        r_active <= r_shadow;
        r_act_dp <= r_sh_dp;
      end
      if (load_i) begin
        r_shadow  <= digits_i;
        r_sh_dp   <= dp_i;
        r_pending <= 1'b1;
      end else if (w_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign seg_o        = r_seg;
  assign an_o         = r_an;
  assign frame_done_o = r_frame_done;
  assign pending_o    = r_pending;
endmodule
